compress_pack_unit: RTL and testbench
=====================================

Name: compress_pack_unit

Overview:
- Parametrised ML-KEM compress-and-pack engine: consumes a 256-coefficient polynomial (mod q=3329) at NUM_COEFF coefficients/beat, applies Compress_d (or plain 12-bit encode) and bit-packs the results LSB-first into OUT_W-bit words.
- Extends the fixed 4-mode compress to all ML-KEM widths d in {1,4,5,10,11,12}.
- Adds a streaming pack buffer with valid/ready on both sides.
- Sits between the polynomial memory read path and the ciphertext/encoded-key output path.

Parameters:
- NUM_COEFF, 4, coefficients per input beat; must divide 256.
- OUT_W, 64, packed output word width; must divide 256 and satisfy NUM_COEFF*12 <= OUT_W.
- BUF_W, 2*OUT_W, pack buffer width in bits.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- zeroize  in  1  synchronous clear of all state, outputs and buffer
- start_i  in  1  one-cycle pulse; begins a polynomial in IDLE
- mode_i  in  3  0:d=1 1:d=4 2:d=5 3:d=10 4:d=11 5:d=12 encode; 6,7 illegal
- coeff_valid_i  in  1  input beat valid
- coeff_ready_o  out  1  input beat accepted when valid&ready
- coeff_i  in  NUM_COEFF*12  coefficient j in bits [12j+11:12j]; j=0 is first in order
- word_valid_o  out  1  packed word available
- word_ready_i  in  1  downstream accepts word
- word_o  out  OUT_W  packed word; earliest bit in bit 0
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after the last word is accepted
- err_o  out  1  one-cycle pulse on illegal mode at start or on any input coefficient >= 3329

Behaviour:
- Reset (rst_b low, asynchronous) and zeroize (synchronous):
  - All outputs become 0; FSM goes to IDLE.
  - Fill count, beat counter, stage register and buffer are cleared.
  - Mid-operation reset or zeroize abandons the polynomial; no done_o is generated.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE:
    - start_i with a legal mode: latch d, clear the beat counter, go to RUN next cycle.
    - start_i with mode 6 or 7: err_o pulses and the FSM stays in IDLE.
    - start_i is ignored outside IDLE.
  - RUN: accept 256/NUM_COEFF beats. After the final accepted beat, go to DRAIN.
  - DRAIN: when the stage register is empty, fill==0 and no word is pending, go to IDLE and pulse done_o in the same cycle.
- Arithmetic:
  - For d<12: y = floor((x*2^d + 1664) / 3329) mod 2^d.
  - For d=12: y = x (ByteEncode12, no rounding).
  - x >= 3329: err_o pulses in the cycle after acceptance. The formula is still applied to the raw 12-bit value, and processing continues.
  - Division is by constant. An exact result is required for all x in 0..4095.
- Pipeline:
  - An accepted beat is compressed into a stage register (1 cycle).
  - The next cycle, its NUM_COEFF*d bits are appended at bit position fill of the buffer.
- Output:
  - word_valid_o = (fill >= OUT_W); word_o = buffer[OUT_W-1:0].
  - On word_valid_o & word_ready_i, the buffer shifts right by OUT_W and fill decreases by OUT_W.
  - An append and a pop in the same cycle are both applied; the appended bits land at fill-OUT_W.
  - word_o is held stable while word_valid_o=1 and word_ready_i=0.
- Input flow control:
  - coeff_ready_o = RUN & beats_remaining & (fill + stage_bits + NUM_COEFF*12 <= BUF_W).
  - This condition is registered-safe, so no beat is ever dropped under backpressure.
- Totals: 256*d is a multiple of OUT_W, so a polynomial produces exactly 256*d/OUT_W words and no partial-word flush exists. Word counts at OUT_W=64: d=1:4, 4:16, 5:20, 10:40, 11:44, 12:48.
- Mode is latched at start; mode_i changes during RUN/DRAIN have no effect.
- Minimum latency: first word_valid_o two cycles after the beat that completes OUT_W bits.

Test Plan:
- d=1, x per beat {0,832,833,2496}, then {2497,1665,3328,0} repeated -> word0 bit pattern LSB-first 0,0,1,1,0,1,0,0 repeating; 4 words total; done_o pulses once.
- d=12, coeff i = i for i=0..255 -> word0 = 0x5004003002001000; 48 words; last word's top 12 bits = 0x0FF.
- d=4, all x=3328 -> y=0; 16 words of 0x0. All x=1664 -> y=8; 16 words of 0x8888888888888888.
- d=11 with word_ready_i low for 20 cycles mid-stream -> coeff_ready_o drops; no word lost or duplicated; 44 words match the golden model.
- start_i with mode_i=6 -> err_o one pulse, busy_o stays 0; input x=4000 in d=10 -> err_o pulse, stream completes with 40 words.
- rst_b low mid-RUN (d=5, after 10 beats) -> all outputs 0 immediately; new start with d=5 yields 20 correct words.

Source files
------------

// File: rtl/compress_pack_unit.sv
// ============================================================================
// Module   : compress_pack_unit
// Purpose  : ML-KEM Compress_d / ByteEncode12 engine with LSB-first bit packer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compress_pack_unit #(
    parameter int NUM_COEFF = 4,
    parameter int OUT_W     = 64,
    parameter int BUF_W     = 2 * OUT_W
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      zeroize,
    input  logic                      start_i,
    input  logic [2:0]                mode_i,
    input  logic                      coeff_valid_i,
    output logic                      coeff_ready_o,
    input  logic [NUM_COEFF*12-1:0]   coeff_i,
    output logic                      word_valid_o,
    input  logic                      word_ready_i,
    output logic [OUT_W-1:0]          word_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int c_in_w      = NUM_COEFF * 12;
    localparam int c_num_beats = 256 / NUM_COEFF;
    localparam int c_beat_w    = $clog2(c_num_beats + 1);
    localparam int c_fill_w    = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            d_q, d_d;
    logic [c_beat_w-1:0]   beat_q, beat_d;
    logic [c_in_w-1:0]     stage_q, stage_d;
    logic                  stage_vld_q, stage_vld_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [c_fill_w-1:0]   fill_q, fill_d;
    logic                  err_q, err_d;

    logic                  w_mode_ok;
    logic [3:0]            w_mode_d;
    logic [c_in_w-1:0]     w_packed;
    logic                  w_bad;
    logic [c_fill_w-1:0]   w_stage_bits;
    logic                  w_coeff_ready;
    logic                  w_word_valid;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_done;
    logic [BUF_W-1:0]      w_base_buf;
    logic [c_fill_w-1:0]   w_base_fill;

    // Quotient of a 24-bit numerator by the constant 3329 is exact for every
    // 12-bit x; the mod 2^d wrap folds values that round up to 2^d back to 0.
    function automatic logic [11:0] compress(input logic [11:0] x, input logic [3:0] d);
        logic [23:0] num;
        logic [11:0] quo;
        logic [11:0] mask;
        if (d == 4'd12) begin
            return x;
        end
        num  = ({12'd0, x} << d) + 24'd1664;
        quo  = 12'(num / 24'd3329);
        mask = (12'd1 << d) - 12'd1;
        return quo & mask;
    endfunction

    always_comb begin
        w_mode_ok = 1'b1;
        w_mode_d  = 4'd1;
        case (mode_i)
            3'd0:    w_mode_d = 4'd1;
            3'd1:    w_mode_d = 4'd4;
            3'd2:    w_mode_d = 4'd5;
            3'd3:    w_mode_d = 4'd10;
            3'd4:    w_mode_d = 4'd11;
            3'd5:    w_mode_d = 4'd12;
            default: w_mode_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_packed = '0;
        w_bad    = 1'b0;
        for (int j = 0; j < NUM_COEFF; j++) begin
            w_bad    = w_bad | (coeff_i[12*j +: 12] >= 12'd3329);
            w_packed = w_packed
                     | (c_in_w'(compress(coeff_i[12*j +: 12], d_q)) << (j * int'(d_q)));
        end
    end

    assign w_stage_bits  = stage_vld_q ? c_fill_w'(NUM_COEFF * int'(d_q)) : '0;
    // Room for the staged beat plus a worst-case new beat keeps the buffer from overflowing.
    assign w_coeff_ready = (state_q == RUN)
                         && (beat_q < c_beat_w'(c_num_beats))
                         && ((int'(fill_q) + int'(w_stage_bits) + c_in_w) <= BUF_W);
    assign w_word_valid  = (fill_q >= c_fill_w'(OUT_W));
    assign w_accept      = coeff_valid_i & w_coeff_ready;
    assign w_pop         = w_word_valid & word_ready_i;

    always_comb begin
        w_base_buf  = w_pop ? (buf_q >> OUT_W) : buf_q;
        w_base_fill = w_pop ? (fill_q - c_fill_w'(OUT_W)) : fill_q;
        buf_d       = w_base_buf;
        fill_d      = w_base_fill;
        if (stage_vld_q) begin
            buf_d  = w_base_buf | (BUF_W'(stage_q) << w_base_fill);
            fill_d = w_base_fill + w_stage_bits;
        end
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        beat_d      = beat_q;
        err_d       = 1'b0;
        w_done      = 1'b0;
        stage_d     = w_accept ? w_packed : '0;
        stage_vld_d = w_accept;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (w_mode_ok) begin
                        d_d     = w_mode_d;
                        beat_d  = '0;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_accept) begin
                    beat_d = beat_q + c_beat_w'(1);
                    if (beat_q == c_beat_w'(c_num_beats - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stage_vld_q && (fill_q == '0)) begin
                    state_d = IDLE;
                    w_done  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_accept && w_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            d_q         <= 4'd1;
            beat_q      <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            buf_q       <= '0;
            fill_q      <= '0;
            err_q       <= 1'b0;
        end else if (zeroize) begin
            state_q     <= IDLE;
            d_q         <= 4'd1;
            beat_q      <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            buf_q       <= '0;
            fill_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            beat_q      <= beat_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
        end
    end

    assign coeff_ready_o = w_coeff_ready;
    assign word_valid_o  = w_word_valid;
    assign word_o        = buf_q[OUT_W-1:0];
    assign busy_o        = (state_q != IDLE);
    assign done_o        = w_done & ~zeroize;
    assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_compress_pack_unit.sv
// ============================================================================
// Module   : tb_compress_pack_unit
// Purpose  : directed self-checking bench for compress_pack_unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_compress_pack_unit;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        zeroize = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  mode_i = 3'd0;
    logic        coeff_valid_i = 1'b0;
    logic        coeff_ready_o;
    logic [47:0] coeff_i = '0;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic [63:0] word_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    compress_pack_unit #(.NUM_COEFF(4), .OUT_W(64), .BUF_W(128)) dut (
        .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start_i(start_i),
        .mode_i(mode_i), .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
        .coeff_i(coeff_i), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .word_o(word_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [47:0]   beats [64];
    logic [63:0]   got   [64];
    logic [3071:0] exp_bits;

    int n_words, n_done, n_err, n_rdy_low, n_unstable;
    bit timed_out;

    function automatic int ref_compress(int x, int d);
        if (d == 12) return x;
        return (((x << d) + 1664) / 3329) % (1 << d);
    endfunction

    function automatic logic [2:0] mode_of(int d);
        case (d)
            1:       return 3'd0;
            4:       return 3'd1;
            5:       return 3'd2;
            10:      return 3'd3;
            11:      return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic build_expected(input int d);
        int y;
        exp_bits = '0;
        for (int b = 0; b < 64; b++) begin
            for (int j = 0; j < 4; j++) begin
                y = ref_compress(int'(beats[b][12*j +: 12]), d);
                for (int k = 0; k < d; k++) exp_bits[(b*4 + j)*d + k] = y[k];
            end
        end
    endtask

    task automatic start_poly(input int d);
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = mode_of(d);
        @(negedge clk);
        start_i = 1'b0;
        mode_i  = 3'd7;
    endtask

    // Cycle-driven stimulus/collector: inputs change at negedge, handshakes
    // are resolved 1ns later so they reflect what the next posedge will do.
    task automatic run_poly(input int stall_start, input int stall_len, input int abort_after);
        int  bi;
        int  post;
        bit  fin;
        bit  hold_prev;
        logic [63:0] prev_word;
        bi = 0; post = 0; fin = 1'b0; hold_prev = 1'b0; prev_word = '0;
        n_words = 0; n_done = 0; n_err = 0; n_rdy_low = 0; n_unstable = 0;
        timed_out = 1'b0;
        for (int w = 0; w < 64; w++) got[w] = 'x;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            coeff_valid_i = (bi < 64);
            coeff_i       = (bi < 64) ? beats[bi] : '0;
            word_ready_i  = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (hold_prev && word_valid_o && word_o !== prev_word) n_unstable++;
            hold_prev = word_valid_o && !word_ready_i;
            prev_word = word_o;
            if (!word_ready_i && !coeff_ready_o && bi < 64) n_rdy_low++;
            if (coeff_valid_i && coeff_ready_o) bi++;
            if (word_valid_o && word_ready_i) begin
                if (n_words < 64) got[n_words] = word_o;
                n_words++;
            end
            if (err_o)  n_err++;
            if (done_o) n_done++;
            if (n_done > 0) begin
                post++;
                if (post > 3) fin = 1'b1;
            end
            if (bi >= abort_after) fin = 1'b1;
        end
        if (!fin) timed_out = 1'b1;
        coeff_valid_i = 1'b0;
        word_ready_i  = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        cmp_cnt++;
        if ({busy_o, word_valid_o, coeff_ready_o, done_o, err_o} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_flags got %b exp 00000", {busy_o, word_valid_o, coeff_ready_o, done_o, err_o});
        end
        cmp_cnt++;
        if (word_o !== 64'h0) begin
            fail_cnt++;
            $display("FAIL reset_word got %h exp 0", word_o);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_d1;
        for (int b = 0; b < 64; b++)
            beats[b] = (b % 2 == 0) ? {12'd2496, 12'd833, 12'd832, 12'd0}
                                    : {12'd0, 12'd3328, 12'd1665, 12'd2497};
        start_poly(1);
        run_poly(1000, 0, 1000);
        cmp_cnt++;
        if (timed_out || n_words !== 4 || n_done !== 1) begin
            fail_cnt++;
            $display("FAIL d1_counts got words=%0d done=%0d to=%0d exp 4 1 0", n_words, n_done, timed_out);
        end
        for (int w = 0; w < 4; w++) begin
            cmp_cnt++;
            if (got[w] !== 64'h2C2C2C2C2C2C2C2C) begin
                fail_cnt++;
                $display("FAIL d1_word%0d got %h exp 2c2c2c2c2c2c2c2c", w, got[w]);
            end
        end
    endtask

    task automatic test_d12;
        for (int b = 0; b < 64; b++)
            for (int j = 0; j < 4; j++) beats[b][12*j +: 12] = 12'(b*4 + j);
        build_expected(12);
        start_poly(12);
        run_poly(1000, 0, 1000);
        cmp_cnt++;
        if (timed_out || n_words !== 48 || n_done !== 1) begin
            fail_cnt++;
            $display("FAIL d12_counts got words=%0d done=%0d to=%0d exp 48 1 0", n_words, n_done, timed_out);
        end
        cmp_cnt++;
        if (got[0] !== 64'h5004003002001000) begin
            fail_cnt++;
            $display("FAIL d12_word0 got %h exp 5004003002001000", got[0]);
        end
        cmp_cnt++;
        if (got[47][63:52] !== 12'h0FF) begin
            fail_cnt++;
            $display("FAIL d12_last_top got %h exp 0ff", got[47][63:52]);
        end
        for (int w = 0; w < 48; w++) begin
            cmp_cnt++;
            if (got[w] !== exp_bits[w*64 +: 64]) begin
                fail_cnt++;
                $display("FAIL d12_word%0d got %h exp %h", w, got[w], exp_bits[w*64 +: 64]);
            end
        end
    endtask

    task automatic test_zeroize;
        for (int b = 0; b < 64; b++) beats[b] = {4{12'd1664}};
        start_poly(4);
        run_poly(1000, 0, 10);
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        #1;
        cmp_cnt++;
        if ({busy_o, word_valid_o, coeff_ready_o, err_o} !== 4'b0 || word_o !== 64'h0) begin
            fail_cnt++;
            $display("FAIL zeroize_clear got flags=%b word=%h exp 0000 0",
                     {busy_o, word_valid_o, coeff_ready_o, err_o}, word_o);
        end
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (done_o) n_done++;
        end
        cmp_cnt++;
        if (n_done !== 0) begin
            fail_cnt++;
            $display("FAIL zeroize_nodone got %0d exp 0", n_done);
        end
    endtask

    task automatic test_d4;
        for (int pass = 0; pass < 2; pass++) begin
            for (int b = 0; b < 64; b++) beats[b] = (pass == 0) ? {4{12'd3328}} : {4{12'd1664}};
            start_poly(4);
            run_poly(1000, 0, 1000);
            cmp_cnt++;
            if (timed_out || n_words !== 16 || n_done !== 1) begin
                fail_cnt++;
                $display("FAIL d4_counts pass%0d got words=%0d done=%0d exp 16 1", pass, n_words, n_done);
            end
            for (int w = 0; w < 16; w++) begin
                cmp_cnt++;
                if (got[w] !== ((pass == 0) ? 64'h0 : 64'h8888888888888888)) begin
                    fail_cnt++;
                    $display("FAIL d4_word%0d pass%0d got %h", w, pass, got[w]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_stall;
        for (int b = 0; b < 64; b++)
            for (int j = 0; j < 4; j++) beats[b][12*j +: 12] = 12'(((b*4 + j) * 13) % 3329);
        build_expected(11);
        start_poly(11);
        run_poly(30, 20, 1000);
        cmp_cnt++;
        if (timed_out || n_words !== 44 || n_done !== 1) begin
            fail_cnt++;
            $display("FAIL d11_counts got words=%0d done=%0d to=%0d exp 44 1 0", n_words, n_done, timed_out);
        end
        cmp_cnt++;
        if (n_rdy_low == 0) begin
            fail_cnt++;
            $display("FAIL d11_ready_drop got %0d low cycles exp >0", n_rdy_low);
        end
        cmp_cnt++;
        if (n_unstable !== 0) begin
            fail_cnt++;
            $display("FAIL d11_hold got %0d changes exp 0", n_unstable);
        end
        for (int w = 0; w < 44; w++) begin
            cmp_cnt++;
            if (got[w] !== exp_bits[w*64 +: 64]) begin
                fail_cnt++;
                $display("FAIL d11_word%0d got %h exp %h", w, got[w], exp_bits[w*64 +: 64]);
            end
        end
    endtask

    task automatic test_errors;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = 3'd6;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        cmp_cnt++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL illegal_mode got err=%b busy=%b exp 1 0", err_o, busy_o);
        end
        @(negedge clk);
        #1;
        cmp_cnt++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            fail_cnt++;
            $display("FAIL illegal_mode_pulse got err=%b busy=%b exp 0 0", err_o, busy_o);
        end
        for (int b = 0; b < 64; b++)
            for (int j = 0; j < 4; j++) beats[b][12*j +: 12] = 12'((b*37 + j*911) % 3329);
        beats[5][11:0] = 12'd4000;
        build_expected(10);
        start_poly(10);
        run_poly(1000, 0, 1000);
        cmp_cnt++;
        if (timed_out || n_words !== 40 || n_done !== 1 || n_err !== 1) begin
            fail_cnt++;
            $display("FAIL d10_counts got words=%0d done=%0d err=%0d exp 40 1 1", n_words, n_done, n_err);
        end
        for (int w = 0; w < 40; w++) begin
            cmp_cnt++;
            if (got[w] !== exp_bits[w*64 +: 64]) begin
                fail_cnt++;
                $display("FAIL d10_word%0d got %h exp %h", w, got[w], exp_bits[w*64 +: 64]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        for (int b = 0; b < 64; b++)
            for (int j = 0; j < 4; j++) beats[b][12*j +: 12] = 12'(((b*4 + j) * 97) % 3329);
        build_expected(5);
        start_poly(5);
        run_poly(1000, 0, 10);
        rst_b = 1'b0;
        #1;
        cmp_cnt++;
        if ({busy_o, word_valid_o, coeff_ready_o, done_o, err_o} !== 5'b0 || word_o !== 64'h0) begin
            fail_cnt++;
            $display("FAIL midrun_reset got flags=%b word=%h exp 00000 0",
                     {busy_o, word_valid_o, coeff_ready_o, done_o, err_o}, word_o);
        end
        @(negedge clk);
        rst_b = 1'b1;
        start_poly(5);
        run_poly(1000, 0, 1000);
        cmp_cnt++;
        if (timed_out || n_words !== 20 || n_done !== 1) begin
            fail_cnt++;
            $display("FAIL d5_counts got words=%0d done=%0d to=%0d exp 20 1 0", n_words, n_done, timed_out);
        end
        for (int w = 0; w < 20; w++) begin
            cmp_cnt++;
            if (got[w] !== exp_bits[w*64 +: 64]) begin
                fail_cnt++;
                $display("FAIL d5_word%0d got %h exp %h", w, got[w], exp_bits[w*64 +: 64]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_d1();
        test_d12();
        test_zeroize();
        test_d4();
        test_back_to_back_stall();
        test_errors();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
